// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer
// Purpose  : picoMips multi-cycle sequencer (fetch/decode/execute/writeback)
//            with handshake wait states, branching and halt.
// Revision : 1.0
// ============================================================================
module stage_sequencer #(
  parameter int ADDR_WIDTH     = 5,
  parameter int HS_SYNC_STAGES = 2,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic                   Handshake,
  input  logic                   WaitHS,
  input  logic                   Branch,
  input  logic [ADDR_WIDTH-1:0]  BranchAddr,
  input  logic                   Halt,
  output logic [ADDR_WIDTH-1:0]  Addr,
  output logic [1:0]             Stage,
  output logic                   ExecStrobe,
  output logic                   WriteStrobe,
  output logic                   Waiting,
  output logic                   Halted,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_WAIT_HI   = 3'd3,
    S_WAIT_LO   = 3'd4,
    S_EXECUTE   = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [HS_SYNC_STAGES-1:0] r_hs_sync;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    w_hs;
  logic                    w_retire;

  assign w_hs     = r_hs_sync[HS_SYNC_STAGES-1];
  assign w_retire = (r_state == S_WRITEBACK);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_hs_sync <= '0;
    end else begin
      r_hs_sync <= {r_hs_sync[HS_SYNC_STAGES-2:0], Handshake};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (Run) w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = S_DECODE;
      S_DECODE:    w_state_nxt = WaitHS ? S_WAIT_HI : S_EXECUTE;
      S_WAIT_HI:   if (w_hs) w_state_nxt = S_WAIT_LO;
      S_WAIT_LO:   if (!w_hs) w_state_nxt = S_EXECUTE;
      S_EXECUTE:   w_state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        if (Halt)     w_state_nxt = S_HALT;
        else if (Run) w_state_nxt = S_FETCH;
        else          w_state_nxt = S_IDLE;
      end
      S_HALT:      w_state_nxt = S_HALT;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Halt freezes the address so the halting instruction stays visible.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_addr <= '0;
    end else if (w_retire && !Halt) begin
      r_addr <= Branch ? BranchAddr : r_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= '0;
    end else if (w_retire && (r_count != '1)) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    Stage = 2'd0;
    case (r_state)
      S_DECODE, S_WAIT_HI, S_WAIT_LO: Stage = 2'd1;
      S_EXECUTE:                      Stage = 2'd2;
      S_WRITEBACK:                    Stage = 2'd3;
      default:                        Stage = 2'd0;
    endcase
  end

  assign ExecStrobe  = (r_state == S_EXECUTE);
  assign WriteStrobe = (r_state == S_WRITEBACK);
  assign Waiting     = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign Halted      = (r_state == S_HALT);
  assign Addr        = r_addr;
  assign InstrCount  = r_count;

endmodule
`default_nettype wire
